// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : MIPS instruction fetch stage. Holds the PC, fetches one 32-bit
//            word per instruction over a req/ack handshake, presents it to
//            decode, and applies jump / taken-branch redirects on consume.
// Ports    : clock, reset        - clock, synchronous active-high reset
//            imem_req/addr       - fetch request and word address (= pc)
//            imem_ack/rdata      - memory response
//            stall               - downstream hold of the presented word
//            take_branch/imm     - taken branch and its raw 16-bit immediate
//            jump/jump_target    - j/jal redirect and its 26-bit instr_index
//            instr/opcode        - captured word and its [31:26] field
//            instr_valid         - instr is ready for consumption
//            pc/pc_plus4         - current PC and PC+4
//            retired             - count of consumed instructions
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        take_branch,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        consume;
   logic [31:0] branch_off;
   logic [31:0] pc_next;

   // Consume happens only on an unstalled EXEC cycle; redirect inputs are
   // meaningful only then.
   assign consume    = (state == EXEC) && !stall;
   assign pc_plus4   = pc + 32'd4;
   assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

   // Redirect priority: jump over taken branch over sequential.
   always_comb begin
      pc_next = pc_plus4;
      if (jump) begin
         pc_next = {pc_plus4[31:28], jump_target, 2'b00};
      end else if (take_branch) begin
         pc_next = pc_plus4 + branch_off;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = REQ;
         REQ:     if (imem_ack) state_next = EXEC;
         EXEC:    if (!stall)   state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instr   <= 32'd0;
         retired <= 32'd0;
      end else begin
         state <= state_next;
         // An ack outside REQ (e.g. a late response after reset) is dropped.
         if ((state == REQ) && imem_ack) begin
            instr <= imem_rdata;
         end
         if (consume) begin
            pc      <= pc_next;
            retired <= retired + 32'd1;
         end
      end
   end

   // Moore outputs decoded from state only.
   assign imem_req    = (state == REQ);
   assign instr_valid = (state == EXEC);
   assign imem_addr   = pc;
   assign opcode      = instr[31:26];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. Three instances with
//            different reset PCs (0, 32'h4000_0008, 32'hFFFF_FFFC) share one
//            clock. Expected fetch results are pushed to a scoreboard queue
//            when the ack is driven and popped when the instruction appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset_a       [3];
   logic        imem_req_a    [3];
   logic [31:0] imem_addr_a   [3];
   logic        imem_ack_a    [3];
   logic [31:0] imem_rdata_a  [3];
   logic        stall_a       [3];
   logic        take_branch_a [3];
   logic [15:0] branch_imm_a  [3];
   logic        jump_a        [3];
   logic [25:0] jump_target_a [3];
   logic [31:0] instr_a       [3];
   logic [5:0]  opcode_a      [3];
   logic        instr_valid_a [3];
   logic [31:0] pc_a          [3];
   logic [31:0] pc_plus4_a    [3];
   logic [31:0] retired_a     [3];

   always #5 clock = ~clock;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam logic [31:0] RPC = (gi == 0) ? 32'h0000_0000 :
                                    (gi == 1) ? 32'h4000_0008 : 32'hFFFF_FFFC;
      instr_fetch #(.RESET_PC(RPC)) u_dut (
         .clock       (clock),
         .reset       (reset_a[gi]),
         .imem_req    (imem_req_a[gi]),
         .imem_addr   (imem_addr_a[gi]),
         .imem_ack    (imem_ack_a[gi]),
         .imem_rdata  (imem_rdata_a[gi]),
         .stall       (stall_a[gi]),
         .take_branch (take_branch_a[gi]),
         .branch_imm  (branch_imm_a[gi]),
         .jump        (jump_a[gi]),
         .jump_target (jump_target_a[gi]),
         .instr       (instr_a[gi]),
         .opcode      (opcode_a[gi]),
         .instr_valid (instr_valid_a[gi]),
         .pc          (pc_a[gi]),
         .pc_plus4    (pc_plus4_a[gi]),
         .retired     (retired_a[gi])
      );
   end

   typedef struct {
      int          d;
      logic [31:0] word;
      logic [31:0] pc;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mpc  [3];
   logic [31:0] mret [3];
   int          n_checks = 0;
   int          n_err    = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs(input int d);
      imem_ack_a[d]    = 1'b0;
      imem_rdata_a[d]  = 32'd0;
      stall_a[d]       = 1'b0;
      take_branch_a[d] = 1'b0;
      branch_imm_a[d]  = 16'd0;
      jump_a[d]        = 1'b0;
      jump_target_a[d] = 26'd0;
   endtask

   task automatic check_reset_vals(input int d, input logic [31:0] rpc);
      chk("rst_req",     {31'd0, imem_req_a[d]},    32'd0);
      chk("rst_valid",   {31'd0, instr_valid_a[d]}, 32'd0);
      chk("rst_pc",      pc_a[d],                   rpc);
      chk("rst_instr",   instr_a[d],                32'd0);
      chk("rst_opcode",  {26'd0, opcode_a[d]},      32'd0);
      chk("rst_retired", retired_a[d],              32'd0);
   endtask

   // Two reset cycles, release, then check imem_req rises one cycle later.
   task automatic do_reset(input int d, input logic [31:0] rpc);
      clear_inputs(d);
      reset_a[d] = 1'b1;
      tick();
      check_reset_vals(d, rpc);
      tick();
      check_reset_vals(d, rpc);
      reset_a[d] = 1'b0;
      check_reset_vals(d, rpc);
      tick();
      chk("req_after_release", {31'd0, imem_req_a[d]}, 32'd1);
      mpc[d]  = rpc;
      mret[d] = 32'd0;
   endtask

   // Entry: #1 after an edge with the instance in REQ.
   task automatic do_instr(input int d, input int waits, input logic [31:0] word,
                           input int stallk, input logic jmp, input logic [25:0] jt,
                           input logic tbr, input logic [15:0] bi,
                           input logic [31:0] exp_next);
      exp_t e;
      chk("req_hi", {31'd0, imem_req_a[d]}, 32'd1);
      chk("addr",   imem_addr_a[d], mpc[d]);
      for (int w = 0; w < waits; w++) begin
         tick();
         chk("req_wait",    {31'd0, imem_req_a[d]}, 32'd1);
         chk("addr_stable", imem_addr_a[d], mpc[d]);
      end
      imem_ack_a[d]   = 1'b1;
      imem_rdata_a[d] = word;
      sb.push_back('{d, word, mpc[d], mret[d]});
      tick();
      imem_ack_a[d]   = 1'b0;
      imem_rdata_a[d] = 32'd0;
      e = sb.pop_front();
      chk("valid",    {31'd0, instr_valid_a[d]}, 32'd1);
      chk("req_lo",   {31'd0, imem_req_a[d]},    32'd0);
      chk("instr",    instr_a[e.d], e.word);
      chk("opcode",   {26'd0, opcode_a[e.d]}, {26'd0, e.word[31:26]});
      chk("pc",       pc_a[e.d], e.pc);
      chk("pc_plus4", pc_plus4_a[e.d], e.pc + 32'd4);
      // Stalled cycles: redirects and a stray ack must all be ignored.
      stall_a[d]       = 1'b1;
      jump_a[d]        = 1'b1;
      jump_target_a[d] = 26'h3FF_FFFF;
      take_branch_a[d] = 1'b1;
      branch_imm_a[d]  = 16'h8000;
      imem_ack_a[d]    = 1'b1;
      imem_rdata_a[d]  = ~word;
      for (int k = 0; k < stallk; k++) begin
         tick();
         chk("stall_valid",   {31'd0, instr_valid_a[d]}, 32'd1);
         chk("stall_instr",   instr_a[d],   e.word);
         chk("stall_pc",      pc_a[d],      e.pc);
         chk("stall_retired", retired_a[d], e.ret);
      end
      clear_inputs(d);
      jump_a[d]        = jmp;
      jump_target_a[d] = jt;
      take_branch_a[d] = tbr;
      branch_imm_a[d]  = bi;
      tick();
      clear_inputs(d);
      mpc[d]  = exp_next;
      mret[d] = e.ret + 32'd1;
      chk("next_pc",     pc_a[d],      mpc[d]);
      chk("retired",     retired_a[d], mret[d]);
      chk("req_again",   {31'd0, imem_req_a[d]},    32'd1);
      chk("valid_after", {31'd0, instr_valid_a[d]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         reset_a[d] = 1'b1;
         clear_inputs(d);
      end
      tick();

      // Instance 0: reset, first fetch, waits/stall, branches, jumps.
      do_reset(0, 32'h0000_0000);
      chk("first_addr", imem_addr_a[0], 32'h0000_0000);
      do_instr(0, 0, 32'h2008_0005, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0004);
      do_instr(0, 3, 32'h8C09_0004, 2, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0008);
      do_instr(0, 0, 32'h0800_0004, 0, 1'b1, 26'h000_0004, 1'b0, 16'd0, 32'h0000_0010);
      do_instr(0, 1, 32'h1000_FFFC, 0, 1'b0, 26'd0, 1'b1, 16'hFFFC, 32'h0000_0004);
      do_instr(0, 0, 32'h0800_0004, 1, 1'b1, 26'h000_0004, 1'b0, 16'd0, 32'h0000_0010);
      do_instr(0, 2, 32'h1000_0003, 0, 1'b0, 26'd0, 1'b1, 16'h0003, 32'h0000_0020);

      // Reset mid-fetch: REQ pending at pc=0x20, reset, then late ack.
      chk("pre_abort_req", {31'd0, imem_req_a[0]}, 32'd1);
      reset_a[0] = 1'b1;
      tick();
      chk("abort_req_drop", {31'd0, imem_req_a[0]}, 32'd0);
      reset_a[0]      = 1'b0;
      imem_ack_a[0]   = 1'b1;
      imem_rdata_a[0] = 32'hDEAD_BEEF;
      tick();
      clear_inputs(0);
      chk("abort_instr",   instr_a[0], 32'd0);
      chk("abort_valid",   {31'd0, instr_valid_a[0]}, 32'd0);
      chk("abort_pc",      pc_a[0], 32'h0000_0000);
      chk("abort_retired", retired_a[0], 32'd0);
      mpc[0]  = 32'h0000_0000;
      mret[0] = 32'd0;
      do_instr(0, 1, 32'h2008_0005, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0004);

      // Instance 1: jump wins over simultaneous taken branch.
      do_reset(1, 32'h4000_0008);
      do_instr(1, 0, 32'h0C00_0010, 0, 1'b1, 26'h000_0010, 1'b1, 16'h0003, 32'h4000_0040);

      // Instance 2: sequential PC wraps to zero.
      do_reset(2, 32'hFFFF_FFFC);
      do_instr(2, 0, 32'h0000_0000, 0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
